apb_rsp_collector: RTL and testbench
====================================

# apb_rsp_collector

Parametrised APB read/write response collector for the AXI4-Lite-to-APB bridge; replaces the purely combinational read-data select. Monitors the bridge's APB master outputs and the per-slave return signals. Selects the active slave's `PRDATA`/`PREADY`/`PSLVERR` and detects completion, decode errors and slave timeouts. Registers the result into a single-entry response buffer with a valid/ready handshake toward the AXI R/B channel logic.

## Interface
- `C_APB_NUM_SLAVES`, 1: number of APB slaves, legal range 1–16.
- `C_DATA_WIDTH`, 32: `PRDATA` width, 8/16/32.
- `C_TIMEOUT`, 256: maximum access-phase cycles before forced error; 0 disables the timeout. Legal range 0–65535.
- `s_axi_aclk`  in  1  single clock.
- `s_axi_areset`  in  1  asynchronous, active-high reset.
- `m_apb_psel`  in  C_APB_NUM_SLAVES  per-slave select from the bridge.
- `m_apb_penable`  in  1  APB access phase.
- `m_apb_pwrite`  in  1  direction of the current transfer.
- `m_apb_prdata`  in  C_APB_NUM_SLAVES*C_DATA_WIDTH  flat read data; slave i occupies bits [i*W +: W].
- `m_apb_pready`  in  C_APB_NUM_SLAVES  per-slave ready.
- `m_apb_pslverr`  in  C_APB_NUM_SLAVES  per-slave error.
- `xfer_done`  out  1  combinational; access completes this cycle, so the bridge drops `psel`/`penable`.
- `rsp_valid`  out  1  response buffer full.
- `rsp_ready`  in  1  consumer accepts the response.
- `rsp_data`  out  C_DATA_WIDTH  captured read data; 0 for writes and errors.
- `rsp_resp`  out  2  AXI response code: 00 OKAY, 10 SLVERR, 11 DECERR.
- `rsp_write`  out  1  response belongs to a write.
- `busy`  out  1  `rsp_valid & ~rsp_ready`; while high, the bridge must not enter an access phase.
- `timeout_err`  out  1  sticky; set by any timeout completion.
- `overrun_err`  out  1  sticky; set when a completion occurs while `busy`.

## Operation
- **Sel decode:** `psel` one-hot selects index i. All-zero or multi-hot = decode error.
- **Access phase:** defined as `penable=1` with `psel != 0`, or `penable=1` with an illegal `psel`.
- **Completion in an access cycle, in priority order:**
  1. `psel` not one-hot → DECERR, data 0.
  2. `pready[i]=1` → OKAY, or SLVERR if `pslverr[i]`. Data = slot i for reads; data 0 for writes and for SLVERR.
  3. `C_TIMEOUT != 0` and wait counter `== C_TIMEOUT-1` → SLVERR, data 0, set `timeout_err`.
- `xfer_done=1` combinationally in the completion cycle only.
- `pready`/`pslverr` of unselected slaves are ignored, and all returns are ignored outside access phases.
- **Wait counter:**
  - Width clog2(C_TIMEOUT+1).
  - Increments each access cycle without completion.
  - Clears on completion and whenever `penable=0`. Saturates and never wraps.
- **FSM states:**
  - IDLE: no buffered response. → FULL on completion.
  - FULL: `rsp_valid=1`.
    - → IDLE on `rsp_ready` with no completion.
    - Stays FULL if `rsp_ready` and a completion coincide; the new response is loaded and the old one is consumed.
    - Completion while FULL and `~rsp_ready`: the new response is dropped, the buffer is unchanged, `overrun_err` is set, and `xfer_done` is still asserted.
- **Buffer fields:** `rsp_data`, `rsp_resp` and `rsp_write` change only on load and are stable while `rsp_valid & ~rsp_ready`.
- **Sticky flags:** cleared only by reset.
- **Reset mid-access:** the counter clears, the buffer empties, and the in-flight access is abandoned. No response is produced for it.

## Timing
- Reset values: `rsp_valid=0`, `rsp_data=0`, `rsp_resp=00`, `rsp_write=0`, `timeout_err=0`, `overrun_err=0`, counter 0. `busy=0` follows from `rsp_valid=0`.
- `xfer_done` has zero latency: same cycle as `pready`, decode error or timeout.
- Response latency: `rsp_valid` rises on the edge ending the completion cycle, so it is visible 1 cycle after `xfer_done`.
- Handshake: transfer occurs on an edge with `rsp_valid & rsp_ready`. Back-to-back responses are sustainable at 1 per cycle.
- Timeout: with `pready` held low, completion occurs in access cycle number C_TIMEOUT, counting the first `penable` cycle as cycle 1.

## Test plan
- **Read OK:** N=4, `psel=0100`, `penable=1`; `pready[2]=1` after 3 wait cycles, prdata slot2=0xCAFE_0002 → `xfer_done` on the 4th access cycle. Next cycle: `rsp_valid=1`, `rsp_data=0xCAFE_0002`, `rsp_resp=00`.
- **Slave error write:** `psel=0001`, `pwrite=1`, `pready[0]=pslverr[0]=1` → `rsp_resp=10`, `rsp_write=1`, `rsp_data=0`.
- **Decode error:** `psel=0011` with `penable=1` → `xfer_done` the same cycle, `rsp_resp=11`, `rsp_data=0`. Repeat with `psel=0000`, `penable=1` → same result.
- **Timeout:** `C_TIMEOUT=8`, `pready` held low → `xfer_done` in access cycle 8, `rsp_resp=10`, `timeout_err=1` and staying 1. Repeat with `C_TIMEOUT=0` held 1000 cycles → no completion.
- **Buffer:** `rsp_ready=0` with response A buffered, then completion B → A retained, `overrun_err=1`. Next, `rsp_ready=1` coinciding with completion C → C loaded, `rsp_valid` stays 1.
- **Reset:** assert `s_axi_areset` asynchronously mid-access with counter=5 and buffer full → all outputs at reset values immediately. After release, the next access completes normally.

Source files
------------

// File: rtl/apb_rsp_collector_if.sv
// Bus bundle between the APB bridge and apb_rsp_collector.
// Carries the bridge's APB master outputs, the per-slave APB returns,
// the completion strobe and the response-buffer handshake.
//   master modport : bridge / R-B channel side (drives APB signals and rsp_ready)
//   slave  modport : collector side (drives xfer_done, rsp_* and busy)
interface apb_rsp_collector_if #(
  parameter int C_APB_NUM_SLAVES = 1,
  parameter int C_DATA_WIDTH     = 32
);
  logic [C_APB_NUM_SLAVES-1:0]              m_apb_psel;
  logic                                     m_apb_penable;
  logic                                     m_apb_pwrite;
  logic [C_APB_NUM_SLAVES*C_DATA_WIDTH-1:0] m_apb_prdata;
  logic [C_APB_NUM_SLAVES-1:0]              m_apb_pready;
  logic [C_APB_NUM_SLAVES-1:0]              m_apb_pslverr;
  logic                                     xfer_done;
  logic                                     rsp_valid;
  logic                                     rsp_ready;
  logic [C_DATA_WIDTH-1:0]                  rsp_data;
  logic [1:0]                               rsp_resp;
  logic                                     rsp_write;
  logic                                     busy;

  modport master (
    output m_apb_psel, m_apb_penable, m_apb_pwrite,
    output m_apb_prdata, m_apb_pready, m_apb_pslverr,
    output rsp_ready,
    input  xfer_done, rsp_valid, rsp_data, rsp_resp, rsp_write, busy
  );

  modport slave (
    input  m_apb_psel, m_apb_penable, m_apb_pwrite,
    input  m_apb_prdata, m_apb_pready, m_apb_pslverr,
    input  rsp_ready,
    output xfer_done, rsp_valid, rsp_data, rsp_resp, rsp_write, busy
  );
endinterface

// File: rtl/apb_rsp_collector.sv
// APB read/write response collector for the AXI4-Lite-to-APB bridge.
// Selects the active slave's PRDATA/PREADY/PSLVERR, detects completion,
// decode errors and access-phase timeouts, and holds the result in a
// single-entry response buffer with a valid/ready handshake.
// Ports:
//   s_axi_aclk   : clock
//   s_axi_areset : asynchronous active-high reset
//   bus          : APB monitor inputs, xfer_done, rsp_* handshake, busy
//   timeout_err  : sticky, set by any timeout completion
//   overrun_err  : sticky, set when a completion arrives while busy
module apb_rsp_collector #(
  parameter int C_APB_NUM_SLAVES = 1,
  parameter int C_DATA_WIDTH     = 32,
  parameter int C_TIMEOUT        = 256
) (
  input  logic                 s_axi_aclk,
  input  logic                 s_axi_areset,
  apb_rsp_collector_if.slave   bus,
  output logic                 timeout_err,
  output logic                 overrun_err
);

  localparam int unsigned NS = C_APB_NUM_SLAVES;
  localparam int unsigned W  = C_DATA_WIDTH;
  localparam int CW = (C_TIMEOUT > 0) ? $clog2(C_TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TO_LAST = (C_TIMEOUT > 0) ? CW'(C_TIMEOUT - 1) : '0;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic {S_IDLE, S_FULL} state_t;

  state_t        r_state;
  logic [W-1:0]  r_data;
  logic [1:0]    r_resp;
  logic          r_write;
  logic [CW-1:0] r_cnt;
  logic          r_timeout_err;
  logic          r_overrun_err;

  logic          w_onehot;
  logic          w_sel_ready;
  logic          w_sel_err;
  logic [W-1:0]  w_sel_data;
  logic          w_dec_done;
  logic          w_rdy_done;
  logic          w_to_done;
  logic          w_done;
  logic [1:0]    w_new_resp;
  logic [W-1:0]  w_new_data;
  logic          w_valid;

  // Slave decode: masking with psel means unselected returns never matter.
  always_comb begin
    w_onehot    = (bus.m_apb_psel != '0) &&
                  ((bus.m_apb_psel & (bus.m_apb_psel - 1'b1)) == '0);
    w_sel_ready = |(bus.m_apb_psel & bus.m_apb_pready);
    w_sel_err   = |(bus.m_apb_psel & bus.m_apb_pslverr);
    w_sel_data  = '0;
    for (int unsigned i = 0; i < NS; i++) begin
      if (bus.m_apb_psel[i]) begin
        w_sel_data = w_sel_data | bus.m_apb_prdata[i*W +: W];
      end
    end
  end

  // Completion sources in priority order: decode error, slave ready, timeout.
  always_comb begin
    w_dec_done = bus.m_apb_penable && !w_onehot;
    w_rdy_done = bus.m_apb_penable && w_onehot && w_sel_ready;
    w_to_done  = (C_TIMEOUT != 0) && bus.m_apb_penable && w_onehot &&
                 !w_sel_ready && (r_cnt == TO_LAST);
    w_done     = w_dec_done || w_rdy_done || w_to_done;

    w_new_resp = RESP_SLVERR;
    w_new_data = '0;
    if (w_dec_done) begin
      w_new_resp = RESP_DECERR;
    end else if (w_rdy_done && !w_sel_err) begin
      w_new_resp = RESP_OKAY;
      if (!bus.m_apb_pwrite) begin
        w_new_data = w_sel_data;
      end
    end
  end

  assign w_valid       = (r_state == S_FULL);
  assign bus.xfer_done = w_done;
  assign bus.rsp_valid = w_valid;
  assign bus.rsp_data  = r_data;
  assign bus.rsp_resp  = r_resp;
  assign bus.rsp_write = r_write;
  assign bus.busy      = w_valid && !bus.rsp_ready;
  assign timeout_err   = r_timeout_err;
  assign overrun_err   = r_overrun_err;

  always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
    if (s_axi_areset) begin
      r_state       <= S_IDLE;
      r_data        <= '0;
      r_resp        <= RESP_OKAY;
      r_write       <= 1'b0;
      r_cnt         <= '0;
      r_timeout_err <= 1'b0;
      r_overrun_err <= 1'b0;
    end else begin
      // Wait counter: only runs through an uncompleted access phase, saturating.
      if (!bus.m_apb_penable || w_done) begin
        r_cnt <= '0;
      end else if (r_cnt != '1) begin
        r_cnt <= r_cnt + 1'b1;
      end

      if (w_to_done) begin
        r_timeout_err <= 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          if (w_done) begin
            r_state <= S_FULL;
            r_data  <= w_new_data;
            r_resp  <= w_new_resp;
            r_write <= bus.m_apb_pwrite;
          end
        end
        S_FULL: begin
          if (w_done && bus.rsp_ready) begin
            // Old entry leaves on this edge while the new one is loaded.
            r_data  <= w_new_data;
            r_resp  <= w_new_resp;
            r_write <= bus.m_apb_pwrite;
          end else if (w_done) begin
            // No room: drop the new response and keep the buffered one.
            r_overrun_err <= 1'b1;
          end else if (bus.rsp_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_rsp_collector.sv
module tb_apb_rsp_collector;

  logic clk;
  logic rst;
  logic to0, ov0, to1, ov1;

  int errors;
  int checks;

  apb_rsp_collector_if #(.C_APB_NUM_SLAVES(4), .C_DATA_WIDTH(32)) bus0 ();
  apb_rsp_collector_if #(.C_APB_NUM_SLAVES(4), .C_DATA_WIDTH(32)) bus1 ();

  apb_rsp_collector #(.C_APB_NUM_SLAVES(4), .C_DATA_WIDTH(32), .C_TIMEOUT(8)) dut0 (
    .s_axi_aclk   (clk),
    .s_axi_areset (rst),
    .bus          (bus0),
    .timeout_err  (to0),
    .overrun_err  (ov0)
  );

  apb_rsp_collector #(.C_APB_NUM_SLAVES(4), .C_DATA_WIDTH(32), .C_TIMEOUT(0)) dut1 (
    .s_axi_aclk   (clk),
    .s_axi_areset (rst),
    .bus          (bus1),
    .timeout_err  (to1),
    .overrun_err  (ov1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  psel;
    logic        en;
    logic        wr;
    logic [3:0]  rdy;
    logic [3:0]  err;
    logic        rr;
    logic        done;
    logic        busy;
    logic        valid;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        wro;
    logic        to;
    logic        ov;
  } vec_t;

  vec_t vec [26];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive0(input logic [3:0] psel, input logic en, input logic wr,
                        input logic [3:0] rdy, input logic [3:0] err, input logic rr);
    bus0.m_apb_psel    = psel;
    bus0.m_apb_penable = en;
    bus0.m_apb_pwrite  = wr;
    bus0.m_apb_pready  = rdy;
    bus0.m_apb_pslverr = err;
    bus0.rsp_ready     = rr;
  endtask

  initial begin
    int ndone;
    errors = 0;
    checks = 0;

    //            psel     en wr rdy      err      rr done busy valid data          resp  wro to ov
    vec[0]  = '{4'b0100, 0, 0, 4'b0000, 4'b0000, 0, 0, 0, 0, 32'h0,          2'b00, 0, 0, 0};
    vec[1]  = '{4'b0100, 1, 0, 4'b0000, 4'b0000, 0, 0, 0, 0, 32'h0,          2'b00, 0, 0, 0};
    vec[2]  = '{4'b0100, 1, 0, 4'b0000, 4'b0000, 0, 0, 0, 0, 32'h0,          2'b00, 0, 0, 0};
    vec[3]  = '{4'b0100, 1, 0, 4'b0000, 4'b0000, 0, 0, 0, 0, 32'h0,          2'b00, 0, 0, 0};
    vec[4]  = '{4'b0100, 1, 0, 4'b0100, 4'b0000, 0, 1, 0, 1, 32'hCAFE_0002,  2'b00, 0, 0, 0};
    vec[5]  = '{4'b0000, 0, 0, 4'b0000, 4'b0000, 1, 0, 0, 0, 32'hCAFE_0002,  2'b00, 0, 0, 0};
    vec[6]  = '{4'b0001, 0, 1, 4'b0000, 4'b0000, 0, 0, 0, 0, 32'hCAFE_0002,  2'b00, 0, 0, 0};
    vec[7]  = '{4'b0001, 1, 1, 4'b0001, 4'b0001, 0, 1, 0, 1, 32'h0,          2'b10, 1, 0, 0};
    vec[8]  = '{4'b0000, 0, 0, 4'b0000, 4'b0000, 1, 0, 0, 0, 32'h0,          2'b10, 1, 0, 0};
    vec[9]  = '{4'b0011, 1, 0, 4'b0011, 4'b0000, 0, 1, 0, 1, 32'h0,          2'b11, 0, 0, 0};
    vec[10] = '{4'b0000, 0, 0, 4'b0000, 4'b0000, 1, 0, 0, 0, 32'h0,          2'b11, 0, 0, 0};
    vec[11] = '{4'b0000, 1, 0, 4'b0000, 4'b0000, 0, 1, 0, 1, 32'h0,          2'b11, 0, 0, 0};
    vec[12] = '{4'b0000, 0, 0, 4'b0000, 4'b0000, 1, 0, 0, 0, 32'h0,          2'b11, 0, 0, 0};
    vec[13] = '{4'b0010, 1, 0, 4'b1101, 4'b1101, 0, 0, 0, 0, 32'h0,          2'b11, 0, 0, 0};
    vec[14] = '{4'b0010, 1, 0, 4'b0010, 4'b0000, 0, 1, 0, 1, 32'hCAFE_0001,  2'b00, 0, 0, 0};
    vec[15] = '{4'b0000, 0, 0, 4'b0000, 4'b0000, 1, 0, 0, 0, 32'hCAFE_0001,  2'b00, 0, 0, 0};
    vec[16] = '{4'b1000, 1, 1, 4'b1000, 4'b0000, 0, 1, 0, 1, 32'h0,          2'b00, 1, 0, 0};
    vec[17] = '{4'b0000, 0, 0, 4'b0000, 4'b0000, 1, 0, 0, 0, 32'h0,          2'b00, 1, 0, 0};
    vec[18] = '{4'b0100, 1, 0, 4'b0100, 4'b0000, 0, 1, 0, 1, 32'hCAFE_0002,  2'b00, 0, 0, 0};
    vec[19] = '{4'b0000, 0, 0, 4'b0000, 4'b0000, 0, 0, 1, 1, 32'hCAFE_0002,  2'b00, 0, 0, 0};
    vec[20] = '{4'b0001, 1, 0, 4'b0001, 4'b0000, 0, 1, 1, 1, 32'hCAFE_0002,  2'b00, 0, 0, 1};
    vec[21] = '{4'b1000, 1, 0, 4'b1000, 4'b0000, 1, 1, 0, 1, 32'hCAFE_0003,  2'b00, 0, 0, 1};
    vec[22] = '{4'b0000, 0, 0, 4'b0000, 4'b0000, 1, 0, 0, 0, 32'hCAFE_0003,  2'b00, 0, 0, 1};
    vec[23] = '{4'b0001, 1, 0, 4'b0001, 4'b0000, 1, 1, 0, 1, 32'hCAFE_0000,  2'b00, 0, 0, 1};
    vec[24] = '{4'b0010, 1, 0, 4'b0010, 4'b0000, 1, 1, 0, 1, 32'hCAFE_0001,  2'b00, 0, 0, 1};
    vec[25] = '{4'b0000, 0, 0, 4'b0000, 4'b0000, 1, 0, 0, 0, 32'hCAFE_0001,  2'b00, 0, 0, 1};

    rst = 1'b1;
    bus0.m_apb_prdata = {32'hCAFE_0003, 32'hCAFE_0002, 32'hCAFE_0001, 32'hCAFE_0000};
    bus1.m_apb_prdata = {32'hCAFE_0003, 32'hCAFE_0002, 32'hCAFE_0001, 32'hCAFE_0000};
    drive0(4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0);
    bus1.m_apb_psel    = '0;
    bus1.m_apb_penable = 1'b0;
    bus1.m_apb_pwrite  = 1'b0;
    bus1.m_apb_pready  = '0;
    bus1.m_apb_pslverr = '0;
    bus1.rsp_ready     = 1'b0;

    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_valid", {31'b0, bus0.rsp_valid}, 32'h0);
    check("rst_data",  bus0.rsp_data, 32'h0);
    check("rst_resp",  {30'b0, bus0.rsp_resp}, 32'h0);
    check("rst_write", {31'b0, bus0.rsp_write}, 32'h0);
    check("rst_busy",  {31'b0, bus0.busy}, 32'h0);
    check("rst_to",    {31'b0, to0}, 32'h0);
    check("rst_ov",    {31'b0, ov0}, 32'h0);

    // Table-driven vectors: one clock cycle each.
    for (int i = 0; i < 26; i++) begin
      @(negedge clk);
      drive0(vec[i].psel, vec[i].en, vec[i].wr, vec[i].rdy, vec[i].err, vec[i].rr);
      #1;
      check($sformatf("v%0d_done", i), {31'b0, bus0.xfer_done}, {31'b0, vec[i].done});
      check($sformatf("v%0d_busy", i), {31'b0, bus0.busy}, {31'b0, vec[i].busy});
      @(posedge clk);
      #1;
      check($sformatf("v%0d_valid", i), {31'b0, bus0.rsp_valid}, {31'b0, vec[i].valid});
      check($sformatf("v%0d_data", i),  bus0.rsp_data, vec[i].data);
      check($sformatf("v%0d_resp", i),  {30'b0, bus0.rsp_resp}, {30'b0, vec[i].resp});
      check($sformatf("v%0d_write", i), {31'b0, bus0.rsp_write}, {31'b0, vec[i].wro});
      check($sformatf("v%0d_to", i),    {31'b0, to0}, {31'b0, vec[i].to});
      check($sformatf("v%0d_ov", i),    {31'b0, ov0}, {31'b0, vec[i].ov});
    end

    // Timeout: pready held low, completion in access cycle 8.
    @(negedge clk);
    drive0(4'b0100, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      drive0(4'b0100, 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0);
      #1;
      check($sformatf("to_done_c%0d", k), {31'b0, bus0.xfer_done}, (k == 8) ? 32'h1 : 32'h0);
    end
    @(posedge clk);
    #1;
    check("to_valid", {31'b0, bus0.rsp_valid}, 32'h1);
    check("to_resp",  {30'b0, bus0.rsp_resp}, 32'h2);
    check("to_data",  bus0.rsp_data, 32'h0);
    check("to_flag",  {31'b0, to0}, 32'h1);
    @(negedge clk);
    drive0(4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b1);
    @(posedge clk);
    #1;
    check("to_drain_valid", {31'b0, bus0.rsp_valid}, 32'h0);
    check("to_sticky",      {31'b0, to0}, 32'h1);

    // Reset mid-access with buffer full and wait counter at 5.
    @(negedge clk);
    drive0(4'b0100, 1'b1, 1'b0, 4'b0100, 4'b0000, 1'b0);
    @(posedge clk);
    #1;
    check("pre_rst_valid", {31'b0, bus0.rsp_valid}, 32'h1);
    @(negedge clk);
    drive0(4'b0001, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0);
    repeat (5) begin
      @(negedge clk);
      drive0(4'b0001, 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0);
    end
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("arst_valid", {31'b0, bus0.rsp_valid}, 32'h0);
    check("arst_data",  bus0.rsp_data, 32'h0);
    check("arst_resp",  {30'b0, bus0.rsp_resp}, 32'h0);
    check("arst_write", {31'b0, bus0.rsp_write}, 32'h0);
    check("arst_busy",  {31'b0, bus0.busy}, 32'h0);
    check("arst_to",    {31'b0, to0}, 32'h0);
    check("arst_ov",    {31'b0, ov0}, 32'h0);
    @(negedge clk);
    drive0(4'b0001, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0);
    rst = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      drive0(4'b0001, 1'b1, 1'b0, (k == 8) ? 4'b0001 : 4'b0000, 4'b0000, 1'b0);
      #1;
      check($sformatf("post_rst_done_c%0d", k), {31'b0, bus0.xfer_done}, (k == 8) ? 32'h1 : 32'h0);
    end
    @(posedge clk);
    #1;
    check("post_rst_valid", {31'b0, bus0.rsp_valid}, 32'h1);
    check("post_rst_data",  bus0.rsp_data, 32'hCAFE_0000);
    check("post_rst_resp",  {30'b0, bus0.rsp_resp}, 32'h0);
    check("post_rst_to",    {31'b0, to0}, 32'h0);
    @(negedge clk);
    drive0(4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b1);

    // Timeout disabled: 1000 access cycles never complete.
    @(negedge clk);
    bus1.m_apb_psel = 4'b0100;
    ndone = 0;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      bus1.m_apb_penable = 1'b1;
      #1;
      if (bus1.xfer_done) ndone++;
    end
    check("notimeout_done_count", ndone, 0);
    @(posedge clk);
    #1;
    check("notimeout_valid", {31'b0, bus1.rsp_valid}, 32'h0);
    check("notimeout_to",    {31'b0, to1}, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
